// File: rtl/bft_client_injector.sv
// bft_client_injector
// Client-side injection endpoint for the butterfly-fat-tree NoC. Buffers
// multi-word client packets in a small FIFO and drives them as addressed
// flits {dest, last, data} into one BFT client port. Each packet is pinned
// to one channel, and channels are chosen round-robin between packets.
// Packets whose destination is out of range are dropped. Packets longer
// than MAX_PKT_FLITS are cut into several packets.
//
// Ports
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_valid/o_ready  client word handshake (o_ready = buffer not full)
//   i_data, i_dest, i_last
//                    client word. i_dest is sampled on the first word only.
//   o_flit_valid     one-hot valid, one bit per channel
//   o_flit           flit shared by all channels
//   i_flit_ready     per-channel ready from the BFT
//   o_err_dest       one-cycle pulse: a packet was dropped (bad dest)
//   o_err_len        one-cycle pulse: a packet was truncated
//   o_pkt_count      packets sent, saturating (BFT_INJ_STATS_EN only)
//   o_stall_count    backpressure cycles, saturating (BFT_INJ_STATS_EN only)
//
// Optional feature: define BFT_INJ_STATS_EN to build the two statistics
// counters. Without it, both counter ports are tied to zero.
//
// State | meaning
// IDLE  | between packets; inspect the head entry and choose a channel
// SEND  | drive the head flit on the latched channel until the packet ends
// DROP  | discard entries of a bad-dest packet, one per cycle

module bft_client_injector #(
  parameter int NUM_CLIENTS   = 16,
  parameter int NUM_CHANNELS  = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int MAX_PKT_FLITS = 16,
  localparam int ADDR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
  localparam int FLIT_W = ADDR_W + 1 + DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [ADDR_W-1:0]       i_dest,
  input  logic                    i_last,
  output logic [NUM_CHANNELS-1:0] o_flit_valid,
  output logic [FLIT_W-1:0]       o_flit,
  input  logic [NUM_CHANNELS-1:0] i_flit_ready,
  output logic                    o_err_dest,
  output logic                    o_err_len,
  output logic [31:0]             o_pkt_count,
  output logic [31:0]             o_stall_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int FC_W  = (MAX_PKT_FLITS > 1) ? $clog2(MAX_PKT_FLITS) : 1;
  // One extra bit so the compare also works when NUM_CLIENTS == 2**ADDR_W.
  localparam logic [ADDR_W:0] NC_L = (ADDR_W + 1)'(NUM_CLIENTS);

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  // Input buffer
  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              in_first;
  logic [ADDR_W-1:0] dest_lat;
  logic [ADDR_W-1:0] push_dest;
  logic              push, pop, full, empty;

  // Output side
  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, rr_q, rr_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              err_dest_q, err_dest_d;
  logic [FLIT_W-1:0] head;
  logic [ADDR_W-1:0] head_dest;
  logic              head_last, dest_bad, cap_hit, eff_last;
  logic [NUM_CHANNELS-1:0] flit_valid;
  logic [FLIT_W-1:0] flit;
  logic              err_len;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign o_ready   = !full;
  assign push      = i_valid && !full;
  // Non-first words reuse the destination captured from the first word.
  assign push_dest = in_first ? i_dest : dest_lat;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {push_dest, i_last, i_data};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_first <= 1'b1;
      dest_lat <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        in_first <= i_last;
        if (in_first) dest_lat <= i_dest;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign head_dest = head[FLIT_W-1 -: ADDR_W];
  assign head_last = head[DATA_WIDTH];
  assign dest_bad  = ({1'b0, head_dest} >= NC_L);
  assign cap_hit   = (fc_q == FC_W'(MAX_PKT_FLITS - 1));
  // The flit at the length cap is forced to close the packet.
  assign eff_last  = head_last || cap_hit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      rr_q       <= '0;
      fc_q       <= '0;
      err_dest_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rr_q       <= rr_d;
      fc_q       <= fc_d;
      err_dest_q <= err_dest_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rr_d       = rr_q;
    fc_d       = fc_q;
    err_dest_d = 1'b0;
    pop        = 1'b0;
    flit_valid = '0;
    flit       = '0;
    err_len    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (dest_bad) begin
            state_d = DROP;
          end else begin
            ch_d    = rr_q;
            fc_d    = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        // Later words of the packet may not have arrived yet; wait for them.
        if (!empty) begin
          flit_valid = NUM_CHANNELS'(1) << ch_q;
          flit       = {head_dest, eff_last, head[DATA_WIDTH-1:0]};
          if (i_flit_ready[ch_q]) begin
            pop     = 1'b1;
            fc_d    = fc_q + 1'b1;
            err_len = cap_hit && !head_last;
            if (eff_last) begin
              rr_d    = (rr_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : rr_q + 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_last) begin
            err_dest_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_flit_valid = flit_valid;
  assign o_flit       = flit;
  assign o_err_len    = err_len;
  assign o_err_dest   = err_dest_q;

`ifdef BFT_INJ_STATS_EN
  logic [31:0] pkt_q, stall_q;
  logic        acc_last, stall;

  assign acc_last = (|flit_valid) && i_flit_ready[ch_q] && flit[DATA_WIDTH];
  assign stall    = (|flit_valid) && !i_flit_ready[ch_q];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pkt_q   <= '0;
      stall_q <= '0;
    end else begin
      if (acc_last && (pkt_q != '1)) pkt_q <= pkt_q + 1'b1;
      if (stall && (stall_q != '1))  stall_q <= stall_q + 1'b1;
    end
  end

  assign o_pkt_count   = pkt_q;
  assign o_stall_count = stall_q;
`else
  assign o_pkt_count   = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_bft_client_injector.sv
module tb_bft_client_injector;

  localparam int NC     = 12;
  localparam int NCH    = 2;
  localparam int DW     = 32;
  localparam int FD     = 8;
  localparam int MAXF   = 4;
  localparam int AW     = 4;
  localparam int FW     = AW + 1 + DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           o_ready;
  logic [DW-1:0]  i_data = '0;
  logic [AW-1:0]  i_dest = '0;
  logic           i_last = 1'b0;
  logic [NCH-1:0] o_flit_valid;
  logic [FW-1:0]  o_flit;
  logic [NCH-1:0] i_flit_ready = '1;
  logic           o_err_dest, o_err_len;
  logic [31:0]    o_pkt_count, o_stall_count;

  bft_client_injector #(
    .NUM_CLIENTS(NC), .NUM_CHANNELS(NCH), .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD), .MAX_PKT_FLITS(MAXF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_dest(i_dest), .i_last(i_last),
    .o_flit_valid(o_flit_valid), .o_flit(o_flit), .i_flit_ready(i_flit_ready),
    .o_err_dest(o_err_dest), .o_err_len(o_err_len),
    .o_pkt_count(o_pkt_count), .o_stall_count(o_stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: packet list -> expected flit stream
  typedef struct {
    logic [FW-1:0] flit;
    int            ch;
    bit            forced;
  } exp_t;

  exp_t exp_q[$];
  bit   m_first = 1;
  int   m_dest = 0, m_chunk = 0, m_rr = 0;
  int   m_err_dest = 0, m_pkts = 0, m_stalls = 0;
  int   seen_err_dest = 0, seen_err_len = 0;
  int   err_cyc = 0;

  logic [FW-1:0] acc_flit[$];
  int            acc_ch[$];
  int            acc_cyc[$];
  int            push_cyc[$];

  bit            prev_stall = 0;
  logic [NCH-1:0] prev_v;
  logic [FW-1:0] prev_f;

  function automatic int onehot_idx(input logic [NCH-1:0] v);
    int r = -1;
    for (int i = 0; i < NCH; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_push(input int d_in, input bit last, input logic [DW-1:0] data);
    exp_t e;
    bit   eff;
    if (m_first) m_dest = d_in;
    m_first = last;
    if (m_dest >= NC) begin
      if (last) m_err_dest++;
    end else begin
      eff      = last || (m_chunk == MAXF - 1);
      e.flit   = {AW'(m_dest), eff, data};
      e.ch     = m_rr;
      e.forced = eff && !last;
      exp_q.push_back(e);
      if (eff) begin
        m_rr    = (m_rr + 1) % NCH;
        m_chunk = 0;
      end else begin
        m_chunk++;
      end
    end
  endtask

  always @(negedge clk) begin
    bit acc;
    if (!rst_n) begin
      exp_q.delete();
      m_first    = 1;
      m_chunk    = 0;
      m_rr       = 0;
      m_pkts     = 0;
      m_stalls   = 0;
      prev_stall = 0;
    end else begin
      acc = |(o_flit_valid & i_flit_ready);
      check("onehot", 64'($countones(o_flit_valid) <= 1), 1);
      if (prev_stall) begin
        check("hold_valid", 64'(o_flit_valid), 64'(prev_v));
        check("hold_flit", 64'(o_flit), 64'(prev_f));
      end
`ifdef BFT_INJ_STATS_EN
      check("pkt_count", 64'(o_pkt_count), 64'(m_pkts));
      check("stall_count", 64'(o_stall_count), 64'(m_stalls));
`else
      check("pkt_count_off", 64'(o_pkt_count), 0);
      check("stall_count_off", 64'(o_stall_count), 0);
`endif
      if (|o_flit_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", 64'(o_flit_valid), 0);
        end else begin
          check("flit", 64'(o_flit), 64'(exp_q[0].flit));
          check("chan", 64'(o_flit_valid), 64'(1) << exp_q[0].ch);
          if (acc) begin
            check("err_len", 64'(o_err_len), 64'(exp_q[0].forced));
            if (exp_q[0].flit[DW]) m_pkts++;
            acc_flit.push_back(o_flit);
            acc_ch.push_back(onehot_idx(o_flit_valid));
            acc_cyc.push_back(cyc);
            void'(exp_q.pop_front());
          end else begin
            m_stalls++;
          end
        end
      end
      if (!acc) check("err_len_idle", 64'(o_err_len), 0);
      if (o_err_len) seen_err_len++;
      if (o_err_dest) begin
        seen_err_dest++;
        err_cyc = cyc;
      end
      prev_stall = (|o_flit_valid) && !acc;
      prev_v     = o_flit_valid;
      prev_f     = o_flit;
      if (i_valid && o_ready) begin
        push_cyc.push_back(cyc);
        model_push(int'(i_dest), i_last, i_data);
      end
    end
  end

  task automatic clear_logs();
    acc_flit.delete();
    acc_ch.delete();
    acc_cyc.delete();
    push_cyc.delete();
  endtask

  task automatic push_word(input logic [AW-1:0] dest, input bit first, input bit last,
                           input logic [DW-1:0] data);
    bit ok = 0;
    int k = 0;
    i_valid = 1'b1;
    i_dest  = first ? dest : ~dest;
    i_last  = last;
    i_data  = data;
    do begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!ok && k < 200);
    if (!ok) check("push_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [AW-1:0] dest, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) push_word(dest, i == 0, i == n - 1, base + DW'(i));
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || o_flit_valid != '0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    if (k >= 500) check("drain_timeout", 64'(k), 0);
    check("err_dest_count", 64'(seen_err_dest), 64'(m_err_dest));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, l0, p0, k;
    logic [FW-1:0] f;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(o_ready), 1);
    check("rst_valid", 64'(o_flit_valid), 0);
    check("rst_flit", 64'(o_flit), 0);
    check("rst_err_dest", 64'(o_err_dest), 0);
    check("rst_err_len", 64'(o_err_len), 0);
    check("rst_pkt_count", 64'(o_pkt_count), 0);
    check("rst_stall_count", 64'(o_stall_count), 0);
    @(posedge clk);
    #1;

    // Single 3-word packet, dest 5, channel 0
    clear_logs();
    send_pkt(4'd5, 3, 32'hA0);
    wait_idle();
    check("t1_count", 64'(acc_flit.size()), 3);
    check("t1_flit0", 64'(acc_flit[0]), 64'({4'd5, 1'b0, 32'hA0}));
    check("t1_flit1", 64'(acc_flit[1]), 64'({4'd5, 1'b0, 32'hA1}));
    check("t1_flit2", 64'(acc_flit[2]), 64'({4'd5, 1'b1, 32'hA2}));
    check("t1_latency", 64'(acc_cyc[0] - push_cyc[0]), 2);
    check("t1_back2back", 64'(acc_cyc[2] - acc_cyc[0]), 2);
    check("t1_ch0", 64'(acc_ch[0]), 0);
    check("t1_ch2", 64'(acc_ch[2]), 0);

    // Round robin: rr is at 1 after the first packet
    clear_logs();
    send_pkt(4'd1, 1, 32'hB0);
    send_pkt(4'd2, 1, 32'hB1);
    send_pkt(4'd3, 1, 32'hB2);
    wait_idle();
    check("t2_count", 64'(acc_flit.size()), 3);
    check("t2_ch0", 64'(acc_ch[0]), 1);
    check("t2_ch1", 64'(acc_ch[1]), 0);
    check("t2_ch2", 64'(acc_ch[2]), 1);
    check("t2_gap", 64'(acc_cyc[1] - acc_cyc[0]), 2);
    check("t2_flit1", 64'(acc_flit[1]), 64'({4'd2, 1'b1, 32'hB1}));

    // Backpressure for 4 cycles on flit 2 of a packet on channel 0
    clear_logs();
    s0 = m_stalls;
`ifdef BFT_INJ_STATS_EN
    p0 = int'(o_stall_count);
`endif
    send_pkt(4'd7, 3, 32'hC0);
    i_flit_ready = 2'b00;
    repeat (4) @(posedge clk);
    #1 i_flit_ready = 2'b11;
    wait_idle();
    check("t3_stalls", 64'(m_stalls - s0), 4);
`ifdef BFT_INJ_STATS_EN
    check("t3_stat_stalls", 64'(int'(o_stall_count) - p0), 4);
`endif
    check("t3_held_gap", 64'(acc_cyc[1] - acc_cyc[0]), 5);
    check("t3_ch", 64'(acc_ch[1]), 0);

    // Fill the buffer while no channel is ready
    clear_logs();
    l0 = seen_err_len;
    i_flit_ready = 2'b00;
    for (int i = 0; i < FD; i++) push_word(4'd8, i == 0, 1'b0, 32'hD0 + 32'(i));
    @(negedge clk);
    check("t4_full_ready", 64'(o_ready), 0);
    @(posedge clk);
    #1 i_flit_ready = 2'b11;
    push_word(4'd8, 1'b0, 1'b0, 32'hD8);
    push_word(4'd8, 1'b0, 1'b1, 32'hD9);
    wait_idle();
    check("t4_count", 64'(acc_flit.size()), 10);
    check("t4_ch4", 64'(acc_ch[4]), 0);
    check("t4_ch8", 64'(acc_ch[8]), 1);
    check("t4_err_len", 64'(seen_err_len - l0), 2);

    // Bad destination dropped, following packet sent normally
    clear_logs();
    e0 = seen_err_dest;
    send_pkt(4'd13, 2, 32'hE0);
    send_pkt(4'd4, 1, 32'hE8);
    wait_idle();
    check("t5_err_dest", 64'(seen_err_dest - e0), 1);
    check("t5_err_dest_time", 64'(err_cyc - push_cyc[0]), 4);
    check("t5_count", 64'(acc_flit.size()), 1);
    check("t5_flit", 64'(acc_flit[0]), 64'({4'd4, 1'b1, 32'hE8}));
    check("t5_latency", 64'(acc_cyc[0] - push_cyc[0]), 5);
    check("t5_ch", 64'(acc_ch[0]), 0);

    // Length cap: 6 words become 4 + 2
    clear_logs();
    l0 = seen_err_len;
    p0 = m_pkts;
    send_pkt(4'd9, 6, 32'hF0);
    wait_idle();
    f = acc_flit[3];
    check("t6_forced_last", 64'(f[DW]), 1);
    f = acc_flit[2];
    check("t6_not_last", 64'(f[DW]), 0);
    f = acc_flit[4];
    check("t6_rem_dest", 64'(f[FW-1 -: AW]), 9);
    check("t6_err_len", 64'(seen_err_len - l0), 1);
    check("t6_ch3", 64'(acc_ch[3]), 1);
    check("t6_ch4", 64'(acc_ch[4]), 0);
    check("t6_pkts", 64'(m_pkts - p0), 2);
`ifdef BFT_INJ_STATS_EN
    check("t6_stat_pkts", 64'(o_pkt_count), 64'(m_pkts));
`endif

    // Reset during flit 2 of 5
    clear_logs();
    i_flit_ready = 2'b00;
    send_pkt(4'd2, 5, 32'h60);
    i_flit_ready = 2'b11;
    k = 0;
    while (acc_flit.size() == 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("t7_first_flit_timeout", 64'(k), 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t7_valid", 64'(o_flit_valid), 0);
    check("t7_ready", 64'(o_ready), 1);
    check("t7_flit", 64'(o_flit), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    send_pkt(4'd3, 1, 32'h70);
    wait_idle();
    check("t7_count", 64'(acc_flit.size()), 1);
    check("t7_ch", 64'(acc_ch[0]), 0);
    check("t7_flit_after", 64'(acc_flit[0]), 64'({4'd3, 1'b1, 32'h70}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
